vx_ibuffer: RTL and testbench
=============================

VX_IBUFFER -- requirements
Module: VX_ibuffer

Interface
- REQ-001: Parameter NUM_WARPS, default 4: number of warps; each warp owns one FIFO.
- REQ-002: Parameter IBUF_SIZE, default 4: entries per warp FIFO; power of two, at least 2.
- REQ-003: Parameter DATAW, default 64: width of the decoded-instruction payload.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: decode_valid  input  1  decoder presents an instruction.
- REQ-007: decode_wid  input  NW_BITS  warp id of the presented instruction.
- REQ-008: decode_data  input  DATAW  instruction payload.
- REQ-009: decode_ready  output  1  FIFO of decode_wid can accept an entry.
- REQ-010: ibuf_valid  output  1  instruction offered to the scoreboard.
- REQ-011: ibuf_wid  output  NW_BITS  warp id of the offered instruction.
- REQ-012: ibuf_data  output  DATAW  payload of the offered instruction.
- REQ-013: ibuf_ready  input  1  scoreboard accepts the offered instruction.
- REQ-014: ibuf_pending  output  NUM_WARPS  bit w set when FIFO w is non-empty (feeds warp scheduler stall logic).

Function
- REQ-015: Push = decode_valid && decode_ready; the payload is written at the tail of FIFO[decode_wid].
- REQ-016: decode_ready = !full[decode_wid], where full means count == IBUF_SIZE; a same-cycle pop gives no push credit.
- REQ-017: Pop = ibuf_valid && ibuf_ready; the head of FIFO[ibuf_wid] is removed.
- REQ-018: Per-warp count width is clog2(IBUF_SIZE+1); read and write pointers are clog2(IBUF_SIZE) bits and wrap modulo IBUF_SIZE.
- REQ-019: Push and pop to the same warp in the same cycle leave count unchanged and advance both pointers.
- REQ-020: No bypass: an entry pushed in cycle N is first visible at ibuf_* in cycle N+1.
- REQ-021: ibuf_valid = OR of the non-empty flags of all warps.
- REQ-022: Grant is round-robin over non-empty warps, starting at the warp after the last popped warp.
- REQ-023: While ibuf_valid && !ibuf_ready, the grant is held, so ibuf_wid and ibuf_data stay stable until the pop.
- REQ-024: The round-robin pointer is updated only on a pop, to that pop's ibuf_wid.
- REQ-025: Within a warp, entries leave in strict FIFO order.
- REQ-026: There is no loss or duplication: for each warp, total pushes minus total pops equals count.
- REQ-027: A push to a full FIFO cannot occur, because decode_ready is low. A pop from an empty FIFO cannot occur, because ibuf_valid only reflects non-empty warps.
- REQ-028: ibuf_pending[w] = (count[w] != 0), taken directly from registered state.

Reset
- REQ-029: On reset all counts, pointers and the round-robin pointer clear to 0.
- REQ-030: In the cycle after reset, ibuf_valid=0, ibuf_pending=0 and decode_ready=1 for every warp.
- REQ-031: Reset asserted mid-operation discards all buffered entries, and any same-cycle push or pop is ignored.
- REQ-032: Payload storage is not reset, and ibuf_data is don't-care while ibuf_valid=0.

Structure
- REQ-033: NUM_WARPS, NW_BITS, IBUF_SIZE and the ibuffer payload typedef live in VX_gpu_pkg.
- REQ-034: Per-warp storage is sub-module VX_ibuffer_fifo (push, pop, data, empty, full, count), instantiated NUM_WARPS times.
- REQ-035: The round-robin arbiter and grant lock are in the top level.

Verification
- REQ-036: After reset, push 4 entries to warp 2 (data 0x10..0x13), ibuf_ready=1 -> output 0x10,0x11,0x12,0x13 on wid 2 in consecutive cycles; first output appears 1 cycle after the first push.
- REQ-037: Fill warp 1 with 4 entries, ibuf_ready=0 -> decode_ready=0 for wid 1, ibuf_pending=4'b0010; a push to wid 0 is still accepted.
- REQ-038: One entry each in warps 0,1,3 with ibuf_ready=1 -> grant order 0,1,3, then ibuf_valid=0.
- REQ-039: ibuf_ready=0 for 5 cycles with warps 0 and 2 pending -> ibuf_wid and ibuf_data are constant through the stall.
- REQ-040: Warp 3 full, simultaneous push and pop of wid 3 -> the push is refused (decode_ready=0), the pop succeeds and count becomes 3.
- REQ-041: Reset with 3 entries buffered -> next cycle ibuf_valid=0, ibuf_pending=0 and all decode_ready=1.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Shared GPU configuration: warp count, instruction-buffer depth and payload
// width, plus the types the instruction buffer is built from.
package vx_gpu_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int IBUF_SIZE = 4;
  localparam int DATAW     = 64;

  typedef logic [DATAW-1:0]   ibuf_data_t;
  typedef logic [NW_BITS-1:0] wid_t;

endpackage

// File: rtl/vx_ibuffer_fifo.sv
// Single-warp instruction FIFO: power-of-two depth, wrapping pointers and an
// occupancy counter that distinguishes full from empty.
module vx_ibuffer_fifo
  import vx_gpu_pkg::*;
#(
  parameter  int DEPTH = IBUF_SIZE,
  parameter  int WIDTH = DATAW,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this logic latch-free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage has no reset; pointers and count define validity, so
  // clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

endmodule

// File: rtl/vx_ibuffer.sv
// Per-warp instruction buffer between decode and scoreboard: one FIFO per warp,
// round-robin selection across non-empty warps, grant held while stalled.
module vx_ibuffer #(
  parameter  int NUM_WARPS = vx_gpu_pkg::NUM_WARPS,
  parameter  int IBUF_SIZE = vx_gpu_pkg::IBUF_SIZE,
  parameter  int DATAW     = vx_gpu_pkg::DATAW,
  localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CNT_W     = $clog2(IBUF_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 decode_valid,
  input  logic [NW_BITS-1:0]   decode_wid,
  input  logic [DATAW-1:0]     decode_data,
  output logic                 decode_ready,
  output logic                 ibuf_valid,
  output logic [NW_BITS-1:0]   ibuf_wid,
  output logic [DATAW-1:0]     ibuf_data,
  input  logic                 ibuf_ready,
  output logic [NUM_WARPS-1:0] ibuf_pending
);

  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic [NUM_WARPS-1:0] empty_vec;
  logic [NUM_WARPS-1:0] full_vec;
  logic [DATAW-1:0]     fifo_data [NUM_WARPS];
  logic [CNT_W-1:0]     fifo_count [NUM_WARPS];

  logic [NW_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [NW_BITS-1:0] lock_wid_q, lock_wid_d;
  logic               lock_q, lock_d;
  logic [NW_BITS-1:0] rr_wid;
  logic               rr_found;
  logic               do_pop;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push_vec[w]     = decode_valid && decode_ready && (decode_wid == NW_BITS'(w));
    assign pop_vec[w]      = do_pop && (ibuf_wid == NW_BITS'(w));
    assign ibuf_pending[w] = (fifo_count[w] != '0);

    vx_ibuffer_fifo #(
      .DEPTH (IBUF_SIZE),
      .WIDTH (DATAW)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_vec[w]),
      .pop      (pop_vec[w]),
      .data_in  (decode_data),
      .data_out (fifo_data[w]),
      .empty    (empty_vec[w]),
      .full     (full_vec[w]),
      .count    (fifo_count[w])
    );
  end

  // A pop in the same cycle deliberately gives no push credit.
  assign decode_ready = !full_vec[decode_wid];

  // Search starts one past the last popped warp and wraps once around.
  always_comb begin
    rr_wid   = rr_ptr_q;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % NUM_WARPS;
      if (!rr_found && !empty_vec[idx]) begin
        rr_wid   = NW_BITS'(idx);
        rr_found = 1'b1;
      end
    end
  end

  assign ibuf_valid = |(~empty_vec);
  assign ibuf_wid   = lock_q ? lock_wid_q : rr_wid;
  assign ibuf_data  = fifo_data[ibuf_wid];
  assign do_pop     = ibuf_valid && ibuf_ready;

  // A stalled offer pins its warp; the locked warp cannot drain until the pop.
  always_comb begin
    lock_d     = ibuf_valid && !ibuf_ready;
    lock_wid_d = ibuf_wid;
    rr_ptr_d   = do_pop ? ibuf_wid : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_wid_q <= lock_wid_d;
    end
  end

endmodule

// File: tb/tb_vx_ibuffer.sv
// Directed bench for vx_ibuffer: ordering, backpressure, round-robin, grant
// hold, full-FIFO refusal and mid-run reset, with hand-computed expectations.
module tb_vx_ibuffer;

  logic        clk;
  logic        reset;
  logic        decode_valid;
  logic [1:0]  decode_wid;
  logic [63:0] decode_data;
  logic        decode_ready;
  logic        ibuf_valid;
  logic [1:0]  ibuf_wid;
  logic [63:0] ibuf_data;
  logic        ibuf_ready;
  logic [3:0]  ibuf_pending;

  int vectors    = 0;
  int miscompares = 0;

  vx_ibuffer #(
    .NUM_WARPS (4),
    .IBUF_SIZE (4),
    .DATAW     (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .decode_valid (decode_valid),
    .decode_wid   (decode_wid),
    .decode_data  (decode_data),
    .decode_ready (decode_ready),
    .ibuf_valid   (ibuf_valid),
    .ibuf_wid     (ibuf_wid),
    .ibuf_data    (ibuf_data),
    .ibuf_ready   (ibuf_ready),
    .ibuf_pending (ibuf_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wid, input logic [63:0] d,
                       input logic rdy);
    decode_valid = v;
    decode_wid   = wid;
    decode_data  = d;
    ibuf_ready   = rdy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] wid, input logic [63:0] d);
    check({tag, "_valid"}, 64'(ibuf_valid), 64'd1);
    check({tag, "_wid"},   64'(ibuf_wid),   64'(wid));
    check({tag, "_data"},  ibuf_data,       d);
  endtask

  task automatic pop_expect(input string tag, input logic [1:0] wid, input logic [63:0] d);
    drive(1'b0, 2'd0, 64'd0, 1'b1);
    check_out(tag, wid, d);
    tick();
  endtask

  task automatic check_all_ready(input string tag);
    for (int w = 0; w < 4; w++) begin
      decode_wid = 2'(w);
      #1;
      check($sformatf("%s_dready%0d", tag, w), 64'(decode_ready), 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 64'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_valid",   64'(ibuf_valid),   64'd0);
    check("rst_pending", 64'(ibuf_pending), 64'd0);
    check_all_ready("rst");

    // Warp 2 streaming: push and pop overlap once the first entry lands.
    drive(1'b1, 2'd2, 64'h10, 1'b1);
    check("no_bypass", 64'(ibuf_valid), 64'd0);
    tick();
    drive(1'b1, 2'd2, 64'h11, 1'b1); check_out("w2_e0", 2'd2, 64'h10); tick();
    drive(1'b1, 2'd2, 64'h12, 1'b1); check_out("w2_e1", 2'd2, 64'h11); tick();
    drive(1'b1, 2'd2, 64'h13, 1'b1); check_out("w2_e2", 2'd2, 64'h12); tick();
    drive(1'b0, 2'd2, 64'h0,  1'b1); check_out("w2_e3", 2'd2, 64'h13); tick();
    drive(1'b0, 2'd0, 64'h0,  1'b0);
    check("w2_drained_valid",   64'(ibuf_valid),   64'd0);
    check("w2_drained_pending", 64'(ibuf_pending), 64'd0);

    // Fill warp 1 under backpressure; warp 0 must still accept.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 64'h20 + 64'(i), 1'b0);
      check($sformatf("w1_fill%0d_dready", i), 64'(decode_ready), 64'd1);
      tick();
    end
    drive(1'b1, 2'd1, 64'h24, 1'b0);
    check("w1_full_dready", 64'(decode_ready), 64'd0);
    check("w1_full_pending", 64'(ibuf_pending), 64'b0010);
    tick();
    drive(1'b1, 2'd0, 64'h30, 1'b0);
    check("w0_accept_dready", 64'(decode_ready), 64'd1);
    check_out("w1_locked", 2'd1, 64'h20);
    tick();
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("w01_pending", 64'(ibuf_pending), 64'b0011);
    check_out("w1_lock_hold", 2'd1, 64'h20);
    pop_expect("drain_a", 2'd1, 64'h20);
    pop_expect("drain_b", 2'd0, 64'h30);
    pop_expect("drain_c", 2'd1, 64'h21);
    pop_expect("drain_d", 2'd1, 64'h22);
    pop_expect("drain_e", 2'd1, 64'h23);
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("drain_empty", 64'(ibuf_valid), 64'd0);

    // One entry each in warps 0, 1, 3: round-robin order 0, 1, 3.
    drive(1'b1, 2'd0, 64'h40, 1'b0); tick();
    drive(1'b1, 2'd1, 64'h41, 1'b0); tick();
    drive(1'b1, 2'd3, 64'h43, 1'b0); tick();
    pop_expect("rr_0", 2'd0, 64'h40);
    pop_expect("rr_1", 2'd1, 64'h41);
    pop_expect("rr_3", 2'd3, 64'h43);
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("rr_empty", 64'(ibuf_valid), 64'd0);

    // Five-cycle stall with warps 0 and 2 pending: offer must not move.
    drive(1'b1, 2'd2, 64'h52, 1'b0); tick();
    drive(1'b1, 2'd0, 64'h50, 1'b0);
    check_out("stall_pre", 2'd2, 64'h52);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'd0, 64'h0, 1'b0);
      check_out($sformatf("stall%0d", i), 2'd2, 64'h52);
      tick();
    end
    pop_expect("stall_pop2", 2'd2, 64'h52);
    pop_expect("stall_pop0", 2'd0, 64'h50);
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("stall_empty", 64'(ibuf_valid), 64'd0);

    // Warp 3 full: simultaneous push refused, pop taken, count drops to 3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 64'h60 + 64'(i), 1'b0);
      tick();
    end
    drive(1'b1, 2'd3, 64'h64, 1'b1);
    check("w3_full_dready", 64'(decode_ready), 64'd0);
    check_out("w3_full_head", 2'd3, 64'h60);
    tick();
    drive(1'b0, 2'd3, 64'h0, 1'b0);
    check("w3_cnt3_dready", 64'(decode_ready), 64'd1);
    check("w3_cnt3_pending", 64'(ibuf_pending), 64'b1000);
    pop_expect("w3_pop1", 2'd3, 64'h61);
    pop_expect("w3_pop2", 2'd3, 64'h62);
    pop_expect("w3_pop3", 2'd3, 64'h63);
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("w3_empty", 64'(ibuf_valid), 64'd0);

    // Mid-run reset with 3 entries buffered and a same-cycle push/pop.
    drive(1'b1, 2'd0, 64'h70, 1'b0); tick();
    drive(1'b1, 2'd1, 64'h71, 1'b0); tick();
    drive(1'b1, 2'd2, 64'h72, 1'b0); tick();
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("prerst_pending", 64'(ibuf_pending), 64'b0111);
    reset = 1'b1;
    drive(1'b1, 2'd3, 64'h7f, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check("midrst_valid",   64'(ibuf_valid),   64'd0);
    check("midrst_pending", 64'(ibuf_pending), 64'd0);
    check_all_ready("midrst");
    drive(1'b1, 2'd1, 64'h80, 1'b0); tick();
    drive(1'b0, 2'd0, 64'h0, 1'b0);
    check_out("postrst", 2'd1, 64'h80);
    check("postrst_pending", 64'(ibuf_pending), 64'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
